// File: rtl/keyboard_char_fifo_decoder_pkg.sv
// Shared scancode/ASCII constants and decoder state type for the keyboard character path.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package keyboard_char_fifo_decoder_pkg;

    // Framing bytes
    localparam logic [7:0] ScanCode_Break  = 8'hF0;
    localparam logic [7:0] ScanCode_Ext    = 8'hE0;

    // Modifier and control make codes
    localparam logic [7:0] ScanCode_ShiftL = 8'h12;
    localparam logic [7:0] ScanCode_ShiftR = 8'h59;
    localparam logic [7:0] ScanCode_Caps   = 8'h58;
    localparam logic [7:0] ScanCode_Space  = 8'h29;
    localparam logic [7:0] ScanCode_Bksp   = 8'h66;
    localparam logic [7:0] ScanCode_Enter  = 8'h5A;

    // Letter make codes a..z
    localparam logic [7:0] ScanCode_A = 8'h1C, ScanCode_B = 8'h32, ScanCode_C = 8'h21;
    localparam logic [7:0] ScanCode_D = 8'h23, ScanCode_E = 8'h24, ScanCode_F = 8'h2B;
    localparam logic [7:0] ScanCode_G = 8'h34, ScanCode_H = 8'h33, ScanCode_I = 8'h43;
    localparam logic [7:0] ScanCode_J = 8'h3B, ScanCode_K = 8'h42, ScanCode_L = 8'h4B;
    localparam logic [7:0] ScanCode_M = 8'h3A, ScanCode_N = 8'h31, ScanCode_O = 8'h44;
    localparam logic [7:0] ScanCode_P = 8'h4D, ScanCode_Q = 8'h15, ScanCode_R = 8'h2D;
    localparam logic [7:0] ScanCode_S = 8'h1B, ScanCode_T = 8'h2C, ScanCode_U = 8'h3C;
    localparam logic [7:0] ScanCode_V = 8'h2A, ScanCode_W = 8'h1D, ScanCode_X = 8'h22;
    localparam logic [7:0] ScanCode_Y = 8'h35, ScanCode_Z = 8'h1A;

    // Top-row digit make codes 0..9
    localparam logic [7:0] ScanCode_0 = 8'h45, ScanCode_1 = 8'h16, ScanCode_2 = 8'h1E;
    localparam logic [7:0] ScanCode_3 = 8'h26, ScanCode_4 = 8'h25, ScanCode_5 = 8'h2E;
    localparam logic [7:0] ScanCode_6 = 8'h36, ScanCode_7 = 8'h3D, ScanCode_8 = 8'h3E;
    localparam logic [7:0] ScanCode_9 = 8'h46;

    // Keypad digit make codes 0..9
    localparam logic [7:0] ScanCode_Kp0 = 8'h70, ScanCode_Kp1 = 8'h69, ScanCode_Kp2 = 8'h72;
    localparam logic [7:0] ScanCode_Kp3 = 8'h7A, ScanCode_Kp4 = 8'h6B, ScanCode_Kp5 = 8'h73;
    localparam logic [7:0] ScanCode_Kp6 = 8'h74, ScanCode_Kp7 = 8'h6C, ScanCode_Kp8 = 8'h75;
    localparam logic [7:0] ScanCode_Kp9 = 8'h7D;

    // ASCII constants
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_BS      = 8'h08;
    localparam logic [7:0] ASCII_CR      = 8'h0D;

    // Scancode framing state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

endpackage

// File: rtl/keyboard_char_lut.sv
// Scancode + case select -> {hit, ascii}; letters honour upper, digits/keypad/control ignore it.
// Latency: combinational.
// Backpressure: not applicable.
module keyboard_char_lut
    import keyboard_char_fifo_decoder_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic       hit,
    output logic [7:0] ascii
);

    logic       is_letter;
    logic       is_digit;
    logic [7:0] idx;

    // Classify the code and find its offset within its character range
    always_comb begin
        is_letter = 1'b1;
        is_digit  = 1'b0;
        idx       = 8'd0;
        case (code)
            ScanCode_A: idx = 8'd0;   ScanCode_B: idx = 8'd1;   ScanCode_C: idx = 8'd2;
            ScanCode_D: idx = 8'd3;   ScanCode_E: idx = 8'd4;   ScanCode_F: idx = 8'd5;
            ScanCode_G: idx = 8'd6;   ScanCode_H: idx = 8'd7;   ScanCode_I: idx = 8'd8;
            ScanCode_J: idx = 8'd9;   ScanCode_K: idx = 8'd10;  ScanCode_L: idx = 8'd11;
            ScanCode_M: idx = 8'd12;  ScanCode_N: idx = 8'd13;  ScanCode_O: idx = 8'd14;
            ScanCode_P: idx = 8'd15;  ScanCode_Q: idx = 8'd16;  ScanCode_R: idx = 8'd17;
            ScanCode_S: idx = 8'd18;  ScanCode_T: idx = 8'd19;  ScanCode_U: idx = 8'd20;
            ScanCode_V: idx = 8'd21;  ScanCode_W: idx = 8'd22;  ScanCode_X: idx = 8'd23;
            ScanCode_Y: idx = 8'd24;  ScanCode_Z: idx = 8'd25;
            default: begin
                is_letter = 1'b0;
                is_digit  = 1'b1;
                case (code)
                    ScanCode_0, ScanCode_Kp0: idx = 8'd0;
                    ScanCode_1, ScanCode_Kp1: idx = 8'd1;
                    ScanCode_2, ScanCode_Kp2: idx = 8'd2;
                    ScanCode_3, ScanCode_Kp3: idx = 8'd3;
                    ScanCode_4, ScanCode_Kp4: idx = 8'd4;
                    ScanCode_5, ScanCode_Kp5: idx = 8'd5;
                    ScanCode_6, ScanCode_Kp6: idx = 8'd6;
                    ScanCode_7, ScanCode_Kp7: idx = 8'd7;
                    ScanCode_8, ScanCode_Kp8: idx = 8'd8;
                    ScanCode_9, ScanCode_Kp9: idx = 8'd9;
                    default:                  is_digit = 1'b0;
                endcase
            end
        endcase
    end

    // Build the ASCII value; anything not recognised reports a miss
    always_comb begin
        hit   = 1'b1;
        ascii = 8'h00;
        if (is_letter)
            ascii = (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + idx;
        else if (is_digit)
            ascii = ASCII_ZERO + idx;
        else begin
            case (code)
                ScanCode_Space: ascii = ASCII_SPACE;
                ScanCode_Bksp:  ascii = ASCII_BS;
                ScanCode_Enter: ascii = ASCII_CR;
                default:        hit   = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_char_fifo_decoder.sv
// PS/2 set-2 scancode framing/shift tracker feeding a show-ahead character FIFO. Option: CAPS_LOCK_EN.
// Latency: byte sampled at a clock edge is visible in the FIFO (char_valid) right after that edge.
// Backpressure: scancodes never stalled; char_ready pops the head; a push into a full FIFO is dropped with overflow.
module keyboard_char_fifo_decoder
    import keyboard_char_fifo_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CHAR_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    sc_data,
    input  logic                          sc_valid,
    output logic [CHAR_W-1:0]             char_data,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          shift_held
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    kbd_state_t        state;
    logic              upper;
    logic              lut_hit;
    logic [7:0]        lut_ascii;
    logic              is_brk, is_ext, is_shift;
    logic              push_req, do_push, do_pop, full, empty;
    logic [CHAR_W-1:0] push_dat;
    logic [CHAR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;

`ifdef CAPS_LOCK_EN
    logic caps;
    assign upper = shift_held ^ caps;
`else
    assign upper = shift_held;
`endif

    keyboard_char_lut u_lut (
        .code  (sc_data),
        .upper (upper),
        .hit   (lut_hit),
        .ascii (lut_ascii)
    );

    assign is_brk   = (sc_data == ScanCode_Break);
    assign is_ext   = (sc_data == ScanCode_Ext);
    assign is_shift = (sc_data == ScanCode_ShiftL) || (sc_data == ScanCode_ShiftR);
    assign push_dat = CHAR_W'(lut_ascii);

    // Decide whether this byte completes a make code that produces a character
    always_comb begin
        push_req = 1'b0;
        if (sc_valid && !is_brk && !is_ext) begin
            case (state)
                ST_IDLE: push_req = lut_hit;
                ST_EXT:  push_req = (sc_data == ScanCode_Enter);
                default: push_req = 1'b0;
            endcase
        end
    end

    // Framing FSM with shift/caps tracking; prefixes always restart framing
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_held <= 1'b0;
`ifdef CAPS_LOCK_EN
            caps       <= 1'b0;
`endif
        end else if (sc_valid) begin
            if (is_brk)
                state <= (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            else if (is_ext)
                state <= ST_EXT;
            else begin
                case (state)
                    ST_IDLE: begin
                        if (is_shift)
                            shift_held <= 1'b1;
`ifdef CAPS_LOCK_EN
                        if (sc_data == ScanCode_Caps)
                            caps <= ~caps;
`endif
                    end
                    ST_BRK: begin
                        if (is_shift)
                            shift_held <= 1'b0;
                    end
                    default: ;
                endcase
                state <= ST_IDLE;
            end
        end
    end

    assign full       = (fifo_count == FULL_CNT);
    assign empty      = (fifo_count == '0);
    assign char_valid = !empty;
    assign do_pop     = char_ready && !empty;
    assign do_push    = push_req && (!full || do_pop);
    assign rd_nxt     = rd_ptr + AW'(1);

    // Storage write; pointers carry the meaning so contents need no reset
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    // FIFO pointers, occupancy, registered show-ahead head and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            char_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push_req && full && !do_pop;
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            // Head follows the entry that will sit at rd_ptr; holds when the FIFO drains
            if (empty && do_push)
                char_data <= push_dat;
            else if (do_pop && fifo_count > (AW+1)'(1))
                char_data <= mem[rd_nxt];
            else if (do_pop && do_push)
                char_data <= push_dat;
        end
    end

endmodule

// File: tb/tb_keyboard_char_fifo_decoder.sv
// Directed-vector bench for keyboard_char_fifo_decoder with hand-computed expected characters.
// Latency: checks sample on the falling edge after each driven byte.
// Backpressure: char_ready driven explicitly to fill, drain and overflow the FIFO.
module tb_keyboard_char_fifo_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sc_data;
    logic       sc_valid;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       shift_held;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keyboard_char_fifo_decoder #(.FIFO_DEPTH(8), .CHAR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sc_data    (sc_data),
        .sc_valid   (sc_valid),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .shift_held (shift_held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One scancode byte, optionally with a simultaneous pop
    task automatic send(input logic [7:0] b, input logic pop);
        @(negedge clk);
        sc_data    = b;
        sc_valid   = 1'b1;
        char_ready = pop;
        @(negedge clk);
        sc_valid   = 1'b0;
        char_ready = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {31'd0, char_valid}, 32'd1);
        chk(tag, {24'd0, char_data}, {24'd0, exp});
        pop1();
    endtask

    logic [7:0] fill_codes [9];
    logic [7:0] fill_chars [9];

    initial begin
        rst = 1'b1; sc_data = 8'h00; sc_valid = 1'b0; char_ready = 1'b0;
        fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        fill_chars = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_data",  {24'd0, char_data},  32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow},   32'd0);
        chk("rst_shift", {31'd0, shift_held}, 32'd0);

        // Empty pop has no effect
        pop1();
        chk("empty_pop_count", {28'd0, fifo_count}, 32'd0);

        // Single make, one-cycle latency, then pop; head holds last value
        send(8'h1C, 1'b0);
        chk("a_valid", {31'd0, char_valid}, 32'd1);
        chk("a_data",  {24'd0, char_data},  32'h61);
        chk("a_count", {28'd0, fifo_count}, 32'd1);
        pop1();
        chk("a_pop_count", {28'd0, fifo_count}, 32'd0);
        chk("a_pop_valid", {31'd0, char_valid}, 32'd0);
        chk("a_hold_data", {24'd0, char_data},  32'h61);

        // Shift framing
        send(8'h12, 1'b0);
        chk("shift_down", {31'd0, shift_held}, 32'd1);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        chk("shift_still", {31'd0, shift_held}, 32'd1);
        send(8'hF0, 1'b0);
        send(8'h12, 1'b0);
        chk("shift_up", {31'd0, shift_held}, 32'd0);
        send(8'h1C, 1'b0);
        chk("shift_count", {28'd0, fifo_count}, 32'd2);
        pop_chk("shift_A", 8'h41);
        pop_chk("shift_a", 8'h61);

        // Extended, keypad, release-only, space/backspace
        send(8'hE0, 1'b0);
        send(8'h5A, 1'b0);
        pop_chk("kp_enter", 8'h0D);
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        chk("ext_drop", {28'd0, fifo_count}, 32'd0);
        send(8'h70, 1'b0);
        pop_chk("kp0", 8'h30);
        send(8'hF0, 1'b0);
        send(8'h16, 1'b0);
        chk("brk_drop", {28'd0, fifo_count}, 32'd0);
        send(8'h29, 1'b0);
        send(8'h66, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h45, 1'b0);
        pop_chk("space", 8'h20);
        pop_chk("bksp", 8'h08);
        pop_chk("enter", 8'h0D);
        pop_chk("digit0", 8'h30);

        // Fill to depth, ninth push overflows
        for (int i = 0; i < 8; i++) send(fill_codes[i], 1'b0);
        chk("full_count", {28'd0, fifo_count}, 32'd8);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        send(fill_codes[8], 1'b0);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {28'd0, fifo_count}, 32'd8);
        @(negedge clk);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);

        // Push + pop at full
        send(8'h3B, 1'b1);
        chk("pp_count", {28'd0, fifo_count}, 32'd8);
        chk("pp_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) pop_chk("drain", fill_chars[i]);
        pop_chk("drain_j", 8'h6A);
        chk("drain_empty", {28'd0, fifo_count}, 32'd0);

        // Reset discards a pending break prefix and shift state
        send(8'h12, 1'b0);
        send(8'hF0, 1'b0);
        do_reset();
        chk("rst_mid_shift", {31'd0, shift_held}, 32'd0);
        send(8'h1C, 1'b0);
        chk("rst_mid_count", {28'd0, fifo_count}, 32'd1);
        pop_chk("rst_mid_a", 8'h61);

        // Caps lock
        do_reset();
`ifdef CAPS_LOCK_EN
        send(8'h58, 1'b0);
        send(8'h1C, 1'b0);
        chk("caps_count", {28'd0, fifo_count}, 32'd1);
        pop_chk("caps_A", 8'h41);
        do_reset();
        send(8'h58, 1'b0);
        send(8'h12, 1'b0);
        send(8'h1C, 1'b0);
        chk("caps_shift_count", {28'd0, fifo_count}, 32'd1);
        pop_chk("caps_shift_a", 8'h61);
`else
        send(8'h58, 1'b0);
        send(8'h1C, 1'b0);
        chk("nocaps_count", {28'd0, fifo_count}, 32'd1);
        pop_chk("nocaps_a", 8'h61);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
